cam_capture: RTL and testbench
==============================

# cam_capture

Camera pixel capture stage sitting directly upstream of the video processing core. It samples the camera's PCLK, HREF (CamHsync), VSYNC and 8-bit data bus in the system clock domain, assembles byte pairs into RGB565 pixels, and emits a single-cycle pixel strobe with X/Y coordinates and frame/line markers. The processing core consumes this stream.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line (byte pairs per HREF-high interval)
- V_ACTIVE, 480, lines per frame
- XW, 10, width of PixX
- YW, 9, width of PixY

Ports:
- CLK  in  1  system clock; the only clock in the block; must be ≥ 3× PCLK frequency
- RST  in  1  synchronous active-high reset
- PCLK  in  1  camera pixel clock, sampled as data
- CamHsync  in  1  camera HREF, high while line bytes are valid
- CamVsync  in  1  camera VSYNC, high pulse marks a frame boundary
- CamData  in  8  camera data byte
- PixValid  out  1  one-cycle strobe; PixData/PixX/PixY valid
- PixData  out  16  RGB565 pixel, first byte in [15:8]
- PixX  out  XW  pixel column
- PixY  out  YW  pixel row
- FrameStart  out  1  one-cycle pulse coincident with PixValid of pixel (0,0)
- LineEnd  out  1  one-cycle pulse on HREF falling edge of an accepted line
- LineErr  out  1  one-cycle pulse when an accepted line ends with a pixel count ≠ H_ACTIVE

## Operation
- PCLK, CamHsync, CamVsync, and CamData each pass through a 2-flop synchronizer; a third flop on PCLK/HREF/VSYNC provides edge detection. A PCLK rise is stage2=1 and stage3=0; the byte is taken from CamData stage2 in that cycle.
- FSM:
  - WAIT_VS: leave on VSYNC rising edge → VS_HIGH.
  - VS_HIGH: leave on VSYNC falling edge → ACTIVE; PixY cleared.
  - ACTIVE: capture. A VSYNC rising edge → VS_HIGH, aborting any partial line with no LineEnd.
- Byte phase: cleared at each HREF rising edge. On each PCLK rise with HREF high, phase 0 stores the high byte; phase 1 completes the pixel and pulses PixValid.
- PixX increments after each emitted pixel and clears at HREF rise. PixY increments at each HREF falling edge in ACTIVE.
- Lines with PixY ≥ V_ACTIVE are ignored: no PixValid, LineEnd, or LineErr.
- Pixels with PixX ≥ H_ACTIVE are dropped; the pixel counter keeps counting for the LineErr check.
- HREF falling with phase 1 pending: the half-pixel is discarded and not counted.
- Counters saturate; they do not wrap within a line or frame.

## Timing
- Reset values: all outputs 0; FSM in WAIT_VS; counters and phase 0.
- Reset mid-frame: no output until a full VSYNC pulse (rise then fall) has been seen. A partial frame is never emitted.
- PixValid asserts 3 CLK cycles after the CLK edge that first registers PCLK high for the second byte of the pair. PixData/PixX/PixY are held until the next PixValid.
- LineEnd and LineErr assert 3 CLK cycles after HREF low is first registered, and never in the same cycle as PixValid.
- HREF and PCLK rising edges detected in the same cycle: HREF rise processed first, so the byte is phase 0.
- No backpressure: the consumer must accept every PixValid.

## Configuration
- CAM_CAPTURE_DECIM_EN defined: 2:1 decimation in both axes. Only even-numbered pixels of even-numbered lines are emitted. PixX/PixY give decimated coordinates (0..H_ACTIVE/2−1, 0..V_ACTIVE/2−1). LineEnd and LineErr apply to even lines only; the LineErr check stays against the full H_ACTIVE.
- Undefined: full resolution, as described above.

## Structure
- Shared package cam_pkg: FSM state enum (WAIT_VS, VS_HIGH, ACTIVE), the RGB565 pixel typedef, and default H_ACTIVE/V_ACTIVE constants shared with the VGA timing side.
- One sub-module, cam_sync: a parameterized-width 3-flop synchronizer/edge detector, instantiated for {PCLK, HREF, VSYNC} and for the data bus (2 stages).

## Test plan
- Reset, then one VSYNC pulse and 2 lines of 640 pairs with bytes 0xF8, 0x1F → 1280 PixValid with PixData=0xF81F; FrameStart at (0,0); LineEnd ×2; LineErr never.
- Assert RST mid-line, release, continue the same frame → zero PixValid until after the next full VSYNC pulse; the next frame starts at (0,0).
- Line of 639 pairs plus one extra byte → 639 PixValid, the half-pixel discarded, LineErr pulses once.
- Line of 650 pairs → PixX 0..639 emitted, 10 dropped, LineErr pulses.
- 490 lines in a frame → lines 480..489 produce no PixValid or LineEnd.
- With CAM_CAPTURE_DECIM_EN, a 640×480 frame → exactly 76800 PixValid, last at PixX=319, PixY=239.

Source files
------------

// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera capture path and the VGA timing side:
// capture FSM states, the RGB565 pixel layout and the default frame geometry.
// -----------------------------------------------------------------------------
package cam_pkg;

  // Default active frame geometry, shared with the VGA timing generator.
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Capture FSM: wait for a frame boundary, sit out the VSYNC pulse, capture.
  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    VS_HIGH = 2'd1,
    ACTIVE  = 2'd2
  } camState_t;

  // RGB565 pixel; the first camera byte of a pair lands in [15:8].
  typedef struct packed {
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
  } rgb565_t;

endpackage

// File: rtl/cam_sync.sv
// -----------------------------------------------------------------------------
// cam_sync
// Multi-bit 2-flop synchronizer with an optional third flop for edge detection.
//
// Parameters:
//   W     - number of independent bits synchronized
//   EDGE  - 1: third flop present, rise/fall outputs active
//           0: plain 2-stage synchronizer, rise/fall tied low
// Ports:
//   CLK     in   system clock
//   raw     in   W  asynchronous inputs
//   synced  out  W  second-stage (metastability-filtered) level
//   rise    out  W  synced=1 and third stage=0
//   fall    out  W  synced=0 and third stage=1
// -----------------------------------------------------------------------------
module cam_sync #(
  parameter int W    = 1,
  parameter bit EDGE = 1'b1
) (
  input  logic         CLK,
  input  logic [W-1:0] raw,
  output logic [W-1:0] synced,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] stage1;
  logic [W-1:0] stage2;

  // NOTE: these flops deliberately have no reset. They keep tracking the pins
  // while the rest of the block is held in reset, so the edge detector sees
  // the true level at release instead of a fake edge from a cleared stage.
  // NOTE: non-blocking assignments make each flop sample the previous stage's
  // old value; blocking here would collapse the chain into one flop.
  always_ff @(posedge CLK) begin
    stage1 <= raw;
    stage2 <= stage1;
  end

  assign synced = stage2;

  generate
    if (EDGE) begin : gEdge
      logic [W-1:0] stage3;

      always_ff @(posedge CLK) begin
        stage3 <= stage2;
      end

      assign rise = stage2 & ~stage3;
      assign fall = ~stage2 & stage3;
    end else begin : gNoEdge
      assign rise = '0;
      assign fall = '0;
    end
  endgenerate

endmodule

// File: rtl/cam_capture.sv
// -----------------------------------------------------------------------------
// cam_capture
// Camera capture stage: samples PCLK/HREF/VSYNC/data in the CLK domain,
// assembles byte pairs into RGB565 pixels and emits a one-cycle pixel strobe
// with X/Y coordinates and frame/line markers. CLK must be >= 3x PCLK.
//
// Build option: CAM_CAPTURE_DECIM_EN
//   defined   - 2:1 decimation in X and Y (even pixels of even lines only,
//               decimated coordinates; LineEnd/LineErr on even lines only)
//   undefined - full resolution
//
// Ports:
//   CLK         in   system clock
//   RST         in   synchronous active-high reset
//   PCLK        in   camera pixel clock (sampled as data)
//   CamHsync    in   camera HREF, high while line bytes are valid
//   CamVsync    in   camera VSYNC, high pulse marks a frame boundary
//   CamData     in   8   camera data byte
//   PixValid    out  one-cycle pixel strobe
//   PixData     out  16  RGB565 pixel, first byte in [15:8]
//   PixX        out  XW  pixel column
//   PixY        out  YW  pixel row
//   FrameStart  out  pulse with PixValid of pixel (0,0)
//   LineEnd     out  pulse at the end of an accepted line
//   LineErr     out  pulse when an accepted line had a pair count != H_ACTIVE
// -----------------------------------------------------------------------------
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PCLK,
  input  logic          CamHsync,
  input  logic          CamVsync,
  input  logic [7:0]    CamData,
  output logic          PixValid,
  output logic [15:0]   PixData,
  output logic [XW-1:0] PixX,
  output logic [YW-1:0] PixY,
  output logic          FrameStart,
  output logic          LineEnd,
  output logic          LineErr
);

`ifdef CAM_CAPTURE_DECIM_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  localparam logic [XW-1:0] H_LIM = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_LIM = YW'(V_ACTIVE);

  // ---------------------------------------------------------------------------
  // Input synchronization: {VSYNC, HREF, PCLK} with edges, data bus level only.
  // ---------------------------------------------------------------------------
  logic [2:0]  ctlLevel;
  logic [2:0]  ctlRise;
  logic [2:0]  ctlFall;
  logic [7:0]  dataS2;
  logic [15:0] unusedDataEdges;
  logic [2:0]  unusedCtl;

  cam_sync #(.W(3), .EDGE(1'b1)) uCtlSync (
    .CLK    (CLK),
    .raw    ({CamVsync, CamHsync, PCLK}),
    .synced (ctlLevel),
    .rise   (ctlRise),
    .fall   (ctlFall)
  );

  cam_sync #(.W(8), .EDGE(1'b0)) uDataSync (
    .CLK    (CLK),
    .raw    (CamData),
    .synced (dataS2),
    .rise   (unusedDataEdges[7:0]),
    .fall   (unusedDataEdges[15:8])
  );

  logic pclkRise, hrefHigh, hrefRise, hrefFall, vsRise, vsFall;

  assign pclkRise  = ctlRise[0];
  assign hrefHigh  = ctlLevel[1];
  assign hrefRise  = ctlRise[1];
  assign hrefFall  = ctlFall[1];
  assign vsRise    = ctlRise[2];
  assign vsFall    = ctlFall[2];
  assign unusedCtl = {ctlLevel[2], ctlLevel[0], ctlFall[0]};

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  camState_t state, nextState;

  always_ff @(posedge CLK) begin
    if (RST) state <= WAIT_VS;
    else     state <= nextState;
  end

  always_comb begin
    // NOTE: the default assigned first covers every path through the case, so
    // no latch is inferred when a branch leaves nextState untouched.
    nextState = state;
    case (state)
      WAIT_VS: if (vsRise) nextState = VS_HIGH;
      VS_HIGH: if (vsFall) nextState = ACTIVE;
      ACTIVE:  if (vsRise) nextState = VS_HIGH;
      default: nextState = WAIT_VS;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line / pixel bookkeeping
  // ---------------------------------------------------------------------------
  logic          phase;      // 1: high byte stored, waiting for low byte
  logic [7:0]    hiByte;
  logic [XW-1:0] pixCnt;     // completed pairs in the current line
  logic [YW-1:0] lineCnt;    // HREF falls seen since frame start
  logic          lineOpen;   // HREF rise of this line was seen in ACTIVE

  logic          inActive, lineLive, curPhase, lineKeep;
  logic          takeByte, pixDone, emit, endEv, errEv;
  logic [XW-1:0] curPixCnt;

  // A VSYNC rise in ACTIVE aborts the line in the same cycle.
  assign inActive  = (state == ACTIVE) && !vsRise;
  // HREF rise wins over a coincident PCLK rise: the byte becomes phase 0.
  assign lineLive  = lineOpen || hrefRise;
  assign curPhase  = hrefRise ? 1'b0 : phase;
  assign curPixCnt = hrefRise ? '0 : pixCnt;
  assign lineKeep  = (lineCnt < V_LIM) && (!DECIM || !lineCnt[0]);

  assign takeByte  = inActive && lineLive && hrefHigh && pclkRise;
  assign pixDone   = takeByte && curPhase;
  // Out-of-range pixels are still counted so LineErr sees the true length.
  assign emit      = pixDone && lineKeep && (curPixCnt < H_LIM) &&
                     (!DECIM || !curPixCnt[0]);
  // hrefFall implies hrefHigh=0, so endEv and emit can never coincide.
  assign endEv     = inActive && hrefFall && lineOpen && lineKeep;
  assign errEv     = endEv && (pixCnt != H_LIM);

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase    <= 1'b0;
      hiByte   <= '0;
      pixCnt   <= '0;
      lineCnt  <= '0;
      lineOpen <= 1'b0;
    end else if (!inActive) begin
      lineOpen <= 1'b0;
      phase    <= 1'b0;
      if (state == VS_HIGH && vsFall) lineCnt <= '0;
    end else begin
      if (hrefRise) begin
        lineOpen <= 1'b1;
        pixCnt   <= '0;
        phase    <= 1'b0;
      end
      if (takeByte) begin
        if (!curPhase) begin
          hiByte <= dataS2;
          phase  <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (curPixCnt != '1) pixCnt <= curPixCnt + XW'(1);
        end
      end
      // A pending half-pixel is simply dropped by clearing the phase.
      if (hrefFall) begin
        lineOpen <= 1'b0;
        phase    <= 1'b0;
        if (lineCnt != '1) lineCnt <= lineCnt + YW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Two-stage output pipeline: event register, then held output register.
  // ---------------------------------------------------------------------------
  logic          evPix, evFirst, evEnd, evErr;
  rgb565_t       evData;
  logic [XW-1:0] evX;
  logic [YW-1:0] evY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      evPix      <= 1'b0;
      evFirst    <= 1'b0;
      evEnd      <= 1'b0;
      evErr      <= 1'b0;
      evData     <= '0;
      evX        <= '0;
      evY        <= '0;
      PixValid   <= 1'b0;
      PixData    <= '0;
      PixX       <= '0;
      PixY       <= '0;
      FrameStart <= 1'b0;
      LineEnd    <= 1'b0;
      LineErr    <= 1'b0;
    end else begin
      evPix   <= emit;
      evFirst <= emit && (curPixCnt == '0) && (lineCnt == '0);
      evEnd   <= endEv;
      evErr   <= errEv;
      if (emit) begin
        evData <= rgb565_t'({hiByte, dataS2});
        evX    <= DECIM ? (curPixCnt >> 1) : curPixCnt;
        evY    <= DECIM ? (lineCnt >> 1) : lineCnt;
      end

      PixValid   <= evPix;
      FrameStart <= evFirst;
      LineEnd    <= evEnd;
      LineErr    <= evErr;
      if (evPix) begin
        PixData <= evData;
        PixX    <= evX;
        PixY    <= evY;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_capture
// Randomized bench for cam_capture with a reduced frame geometry. A line-level
// reference model pushes expected pixels and line-end results into queues; an
// independent monitor pops and compares whenever the DUT strobes an output.
// -----------------------------------------------------------------------------
module tb_cam_capture;

  localparam int H  = 16;
  localparam int V  = 6;
  localparam int XW = 6;
  localparam int YW = 4;

`ifdef CAM_CAPTURE_DECIM_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          PCLK;
  logic          CamHsync;
  logic          CamVsync;
  logic [7:0]    CamData;
  logic          PixValid;
  logic [15:0]   PixData;
  logic [XW-1:0] PixX;
  logic [YW-1:0] PixY;
  logic          FrameStart;
  logic          LineEnd;
  logic          LineErr;

  cam_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .XW       (XW),
    .YW       (YW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PCLK       (PCLK),
    .CamHsync   (CamHsync),
    .CamVsync   (CamVsync),
    .CamData    (CamData),
    .PixValid   (PixValid),
    .PixData    (PixData),
    .PixX       (PixX),
    .PixY       (PixY),
    .FrameStart (FrameStart),
    .LineEnd    (LineEnd),
    .LineErr    (LineErr)
  );

  always #5 CLK = ~CLK;

  typedef logic [7:0] byteQ_t[$];
  typedef struct {
    logic [15:0] data;
    int          x;
    int          y;
    bit          first;
  } pixExp_t;

  pixExp_t pixQ[$];
  bit      lineQ[$];

  int compared   = 0;
  int mismatched = 0;
  int pixSeen    = 0;
  int pixPushed  = 0;

  // Model state: armed after a full VSYNC pulse since reset; line index.
  bit armed  = 1'b0;
  int modelY = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name, input string what);
    compared++;
    mismatched++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one call per camera line, working on the byte list.
  // ---------------------------------------------------------------------------
  task automatic modelLine(input byteQ_t bytes, input bit completes);
    int      pairs;
    bit      keep;
    pixExp_t e;
    pairs = bytes.size() / 2;
    keep  = armed && (modelY < V) && (!DECIM || (modelY % 2 == 0));
    if (keep) begin
      for (int i = 0; i < pairs; i++) begin
        if (i < H && (!DECIM || (i % 2 == 0))) begin
          e.data  = {bytes[2*i], bytes[2*i+1]};
          e.x     = DECIM ? i / 2 : i;
          e.y     = DECIM ? modelY / 2 : modelY;
          e.first = (i == 0) && (modelY == 0);
          pixQ.push_back(e);
          pixPushed++;
        end
      end
      if (completes) lineQ.push_back(pairs != H);
    end
    if (armed && completes) modelY++;
  endtask

  // ---------------------------------------------------------------------------
  // Camera-side drivers (PCLK = 4 CLK periods)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic makeBytes(output byteQ_t b, input int n, input bit fixedData);
    b = {};
    for (int i = 0; i < n; i++)
      b.push_back(fixedData ? ((i % 2 == 0) ? 8'hF8 : 8'h1F) : 8'($urandom));
  endtask

  // simult=1 raises HREF together with the first PCLK rise.
  task automatic sendBytes(input byteQ_t bytes, input bit simult);
    for (int i = 0; i < bytes.size(); i++) begin
      CamData = bytes[i];
      PCLK    = 1'b0;
      if (i == 0 && !simult) CamHsync = 1'b1;
      tick(2);
      PCLK = 1'b1;
      if (i == 0) CamHsync = 1'b1;
      tick(2);
    end
  endtask

  task automatic endLine();
    PCLK = 1'b0;
    tick(2);
    CamHsync = 1'b0;
    tick(6);
  endtask

  task automatic camLine(input int n, input bit fixedData, input bit simult);
    byteQ_t b;
    makeBytes(b, n, fixedData);
    modelLine(b, 1'b1);
    sendBytes(b, simult);
    endLine();
  endtask

  task automatic vsPulse();
    CamVsync = 1'b1;
    tick(8);
    CamVsync = 1'b0;
    tick(8);
    armed  = 1'b1;
    modelY = 0;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_valid"},  PixValid,   0);
    check({tag, "_data"},   PixData,    0);
    check({tag, "_x"},      PixX,       0);
    check({tag, "_y"},      PixY,       0);
    check({tag, "_fstart"}, FrameStart, 0);
    check({tag, "_lend"},   LineEnd,    0);
    check({tag, "_lerr"},   LineErr,    0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin : monitor
    pixExp_t e;
    bit      expErr;
    if (PixValid) begin
      pixSeen++;
      if (pixQ.size() == 0) begin
        failNow("unexpected_pix", $sformatf("PixValid at x=%0d y=%0d, none expected", PixX, PixY));
      end else begin
        e = pixQ.pop_front();
        check("pix_data",    PixData,    e.data);
        check("pix_x",       PixX,       e.x);
        check("pix_y",       PixY,       e.y);
        check("frame_start", FrameStart, e.first);
      end
    end else if (FrameStart) begin
      check("fstart_needs_pix", PixValid, 1);
    end
    if (LineEnd) begin
      check("lend_overlap_pix", PixValid, 0);
      if (lineQ.size() == 0) begin
        failNow("unexpected_lend", "LineEnd with no line expected");
      end else begin
        expErr = lineQ.pop_front();
        check("line_err", LineErr, expErr);
      end
    end else if (LineErr) begin
      check("lerr_needs_lend", LineEnd, 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    byteQ_t bA;
    byteQ_t bB;
    RST      = 1'b1;
    PCLK     = 1'b0;
    CamHsync = 1'b0;
    CamVsync = 1'b0;
    CamData  = '0;
    tick(6);
    checkIdle("reset");
    RST = 1'b0;
    tick(2);

    // No VSYNC seen yet: this line must be ignored.
    camLine(2*H, 1'b0, 1'b0);

    // Frame 1: fixed-colour lines, then length corner cases, then overflow.
    vsPulse();
    camLine(2*H, 1'b1, 1'b0);
    camLine(2*H, 1'b1, 1'b1);
    camLine(2*H - 1, 1'b0, 1'b0);   // one pair short plus a half pixel
    camLine(2*H + 20, 1'b0, 1'b1);  // ten extra pairs
    camLine(2*70, 1'b0, 1'b0);      // pair counter saturates
    repeat (13)                     // past V and past lineCnt saturation
      camLine(2*$urandom_range(H-2, H+2) + $urandom_range(0, 1), 1'b0,
              1'($urandom_range(0, 1)));

    // Frame 2: VSYNC rise in the middle of a line aborts it.
    vsPulse();
    camLine(2*H, 1'b0, 1'b0);
    makeBytes(bA, 11, 1'b0);
    modelLine(bA, 1'b0);
    sendBytes(bA, 1'b0);
    tick(8);
    CamVsync = 1'b1;
    tick(8);
    PCLK     = 1'b0;
    CamHsync = 1'b0;
    tick(4);
    CamVsync = 1'b0;
    tick(8);
    armed  = 1'b1;
    modelY = 0;

    // Frame 3: continues after abort, then reset in the middle of a line.
    camLine(2*H, 1'b0, 1'b1);
    camLine(2*H + 1, 1'b0, 1'b0);
    makeBytes(bA, 12, 1'b0);
    makeBytes(bB, 2*H - 12, 1'b0);
    modelLine(bA, 1'b0);
    sendBytes(bA, 1'b0);
    tick(8);
    RST = 1'b1;
    tick(3);
    checkIdle("midreset");
    RST   = 1'b0;
    armed = 1'b0;
    sendBytes(bB, 1'b0);
    endLine();
    camLine(2*H, 1'b0, 1'b0);
    camLine(2*H, 1'b0, 1'b1);

    // Frame 4: clean frame after the full VSYNC pulse, restarting at (0,0).
    vsPulse();
    repeat (4)
      camLine(2*$urandom_range(H-1, H+1), 1'b0, 1'($urandom_range(0, 1)));

    tick(20);
    check("pix_queue_left",  pixQ.size(),  0);
    check("line_queue_left", lineQ.size(), 0);
    check("pix_count",       pixSeen,      pixPushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
